shift_register_gen: RTL and testbench
=====================================

# shift_register_gen

Parametrised multi-digit shift register for the shift-and-add datapath, generalising the fixed 2-bit right shifter. It supports configurable digit width, shift direction, and serial-fill, rotate and arithmetic modes. A built-in step counter flags completion of a full pass, so the multiplier control FSM no longer needs its own shift counter. It sits between the operand loader and the adder/accumulator stage.

## Interface
- `WIDTH`, 8: register width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 2: bits moved per shift step; 1 ≤ `DIGIT` < `WIDTH`.
- `STEPS` (localparam) = `WIDTH/DIGIT`; `CW` (localparam) = `$clog2(STEPS+1)`.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `clear` in 1: active-low synchronous clear of register, count and done.
- `load_enable` in 1: load `parallel_in`, restart the pass.
- `shift_enable` in 1: perform one shift step.
- `dir` in 1: 0 = right (toward LSB), 1 = left.
- `mode` in 2: 00 serial fill, 01 rotate, 10 arithmetic, 11 treated as 00.
- `parallel_in` in `WIDTH`: parallel load data.
- `serial_in` in `DIGIT`: fill digit in serial mode.
- `parallel_out` out `WIDTH`: register contents.
- `serial_out` out `DIGIT`: digit that the next shift ejects (combinational from register and `dir`).
- `shift_count` out `CW`: shifts performed since last load/clear.
- `done` out 1: high when `shift_count == STEPS`.

## Operation
- Priority per edge: `reset`=0, then `clear`=0, then `load_enable`, then `shift_enable`, then hold.
- Reset or clear: `parallel_out`=0, `shift_count`=0, `done`=0.
- Load: `parallel_out`=`parallel_in`, `shift_count`=0, `done`=0. A load issued while `done`=1 starts a new pass.
- Shift right (`dir`=0): register shifts down by `DIGIT`. The vacated top digit is filled as follows:
  - mode 00: `serial_in`.
  - mode 01: the old low digit (rotate).
  - mode 10: `DIGIT` copies of the old MSB (sign extension).
- Shift left (`dir`=1): register shifts up by `DIGIT`. The vacated low digit is filled as follows:
  - mode 00: `serial_in`.
  - mode 01: the old top digit.
  - mode 10: zeros.
- `serial_out`: `parallel_out[DIGIT-1:0]` when `dir`=0; `parallel_out[WIDTH-1 -: DIGIT]` when `dir`=1. Valid before the edge that ejects it.
- Each accepted shift increments `shift_count`. `done` is registered and rises on the edge where the count reaches `STEPS`.
- While `done`=1, `shift_enable` is ignored: register and count hold (saturation). Only load, clear or reset leave the done state.
- `dir` and `mode` are sampled per shift. Changing them mid-pass is legal and affects only subsequent steps.
- States (implicit, from count/done): IDLE (count 0), SHIFTING (0 < count < STEPS), DONE.

## Timing
- Single-cycle latency: an operation at edge N is visible on `parallel_out`, `shift_count` and `done` after edge N.
- `serial_out` follows `parallel_out` and `dir` combinationally with zero cycles.
- Reset is synchronous: asserting `reset` changes nothing until the next `clk` edge.
- Reset or clear asserted mid-pass zeroes all state on that edge, whatever `load_enable`/`shift_enable` are doing.
- Simultaneous load and shift: load wins, and the count becomes 0, not 1.
- Reset values: `parallel_out`=0, `serial_out`=0, `shift_count`=0, `done`=0.

## Structure
- Package `shift_pkg`:
  - `shift_mode_t` enum: `SHIFT_SERIAL`, `SHIFT_ROTATE`, `SHIFT_ARITH`.
  - `DIR_RIGHT`/`DIR_LEFT` constants.
  - Function computing the fill digit from mode, dir, old register and `serial_in`.
- One sub-module, `shift_step_counter`: saturating up-counter with parameter `STEPS`. It has sync clear, restart (load) and increment inputs and drives `count` and `done`. The top-level gates `shift_enable` with `!done`.
- Parameter legality (`WIDTH % DIGIT == 0`) is checked with an elaboration-time assertion.

## Test plan
All scenarios use `WIDTH`=8, `DIGIT`=2.
- Serial right: load 8'hB4, `mode`=00, `dir`=0, `serial_in`=2'b11. `serial_out`=2'b00 before the shift; one shift gives 8'hED, `serial_out`=2'b01, `shift_count`=1.
- Rotate left: load 8'h81, `mode`=01, `dir`=1. First shift gives 8'h06; four shifts return 8'h81 with `done`=1.
- Arithmetic: load 8'h80, `mode`=10. Right shifts give 8'hE0 then 8'hF8. Load 8'h81, one left shift gives 8'h04.
- Saturation: 4 shifts give `done`=1, `shift_count`=4. A 5th `shift_enable` leaves register and count unchanged. Load 8'h3C gives `done`=0, count 0.
- Priority: `load_enable` and `shift_enable` together load `parallel_in` with count 0. `clear`=0 together with load gives all zeros.
- Reset mid-pass: after 2 shifts, drive `reset`=0 between edges. Outputs hold until the next edge, then all outputs are 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and the fill-digit rule for the generic shift register.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SERIAL = 2'b00,
        SHIFT_ROTATE = 2'b01,
        SHIFT_ARITH  = 2'b10
    } shift_mode_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Digits are passed zero-extended to this width so one function serves any DIGIT.
    localparam int MAX_DIGIT = 32;

    function automatic logic [MAX_DIGIT-1:0] fill_digit(
        input logic [1:0]           mode,
        input logic                 dir,
        input logic [MAX_DIGIT-1:0] low_digit,
        input logic [MAX_DIGIT-1:0] top_digit,
        input logic [MAX_DIGIT-1:0] serial_in,
        input logic                 msb
    );
        logic [MAX_DIGIT-1:0] f;
        f = serial_in;
        case (mode)
            SHIFT_ROTATE: f = (dir == DIR_RIGHT) ? low_digit : top_digit;
            SHIFT_ARITH:  f = (dir == DIR_RIGHT) ? {MAX_DIGIT{msb}} : '0;
            default:      f = serial_in;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Saturating step counter: counts accepted shifts, flags a full pass with done.
// Latency: count/done update on the edge after restart/incr/clear.
// Backpressure: increments are ignored once done is set; only restart/clear/reset leave it.
module shift_step_counter #(
    parameter  int STEPS = 4,
    localparam int CW    = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          restart,
    input  logic          incr,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (!clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (restart) begin
            count <= '0;
            done  <= 1'b0;
        end else if (incr && !done) begin
            count <= count + 1'b1;
            done  <= (count == CW'(STEPS - 1));
        end
    end

endmodule

// File: rtl/shift_register_gen.sv
// Multi-digit shift register with serial-fill, rotate and arithmetic modes plus pass counter.
// Latency: one cycle for load/shift/clear; serial_out is combinational from register and dir.
// Backpressure: shift_enable is ignored while done is high until load, clear or reset.
module shift_register_gen
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIGIT = 2,
    localparam int STEPS = WIDTH / DIGIT,
    localparam int CW    = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_enable,
    input  logic             shift_enable,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic [DIGIT-1:0] serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic [DIGIT-1:0] serial_out,
    output logic [CW-1:0]    shift_count,
    output logic             done
);

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("shift_register_gen: WIDTH must be a multiple of DIGIT");
    end
    if (DIGIT < 1 || DIGIT >= WIDTH || DIGIT >= MAX_DIGIT) begin : g_bad_digit
        $error("shift_register_gen: DIGIT out of range");
    end

    logic [WIDTH-1:0]     sr;
    logic                 shift_go;
    logic [MAX_DIGIT-1:0] fill_wide;
    logic [DIGIT-1:0]     fill;
    logic                 unused_fill;

    assign shift_go = shift_enable && !done;

    assign fill_wide = fill_digit(mode, dir,
                                  MAX_DIGIT'(sr[DIGIT-1:0]),
                                  MAX_DIGIT'(sr[WIDTH-1 -: DIGIT]),
                                  MAX_DIGIT'(serial_in),
                                  sr[WIDTH-1]);
    assign fill        = fill_wide[DIGIT-1:0];
    assign unused_fill = ^fill_wide;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= '0;
        end else if (!clear) begin
            sr <= '0;
        end else if (load_enable) begin
            sr <= parallel_in;
        end else if (shift_go) begin
            if (dir == DIR_RIGHT) sr <= {fill, sr[WIDTH-1:DIGIT]};
            else                  sr <= {sr[WIDTH-DIGIT-1:0], fill};
        end
    end

    shift_step_counter #(.STEPS(STEPS)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .restart (load_enable),
        .incr    (shift_go),
        .count   (shift_count),
        .done    (done)
    );

    assign parallel_out = sr;
    assign serial_out   = (dir == DIR_LEFT) ? sr[WIDTH-1 -: DIGIT] : sr[DIGIT-1:0];

endmodule

// File: tb/tb_shift_register_gen.sv
// Bench for shift_register_gen (WIDTH=8, DIGIT=2): vector table, corner sequences, random vs model.
module tb_shift_register_gen;

    localparam int W     = 8;
    localparam int D     = 2;
    localparam int STEPS = W / D;
    localparam int MASK  = (1 << W) - 1;
    localparam int DMASK = (1 << D) - 1;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         load_enable;
    logic         shift_enable;
    logic         dir;
    logic [1:0]   mode;
    logic [W-1:0] parallel_in;
    logic [D-1:0] serial_in;
    logic [W-1:0] parallel_out;
    logic [D-1:0] serial_out;
    logic [2:0]   shift_count;
    logic         done;

    int pass_cnt = 0;
    int total_cnt = 0;

    shift_register_gen #(.WIDTH(W), .DIGIT(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .dir          (dir),
        .mode         (mode),
        .parallel_in  (parallel_in),
        .serial_in    (serial_in),
        .parallel_out (parallel_out),
        .serial_out   (serial_out),
        .shift_count  (shift_count),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       clr_n;
        logic       ld;
        logic       sh;
        logic       dr;
        logic [1:0] md;
        logic [7:0] pin;
        logic [1:0] sin;
        logic [7:0] eq;
        logic [2:0] ec;
        logic       ed;
        logic [1:0] eso;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic rst_n, logic clr_n, logic ld, logic sh, logic dr,
                                logic [1:0] md, logic [7:0] pin, logic [1:0] sin,
                                logic [7:0] eq, logic [2:0] ec, logic ed, logic [1:0] eso);
        vec_t v;
        v.rst_n = rst_n; v.clr_n = clr_n; v.ld = ld; v.sh = sh; v.dr = dr; v.md = md;
        v.pin = pin; v.sin = sin; v.eq = eq; v.ec = ec; v.ed = ed; v.eso = eso;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rst_n, input logic clr_n, input logic ld, input logic sh,
                         input logic dr, input logic [1:0] md, input logic [7:0] pin,
                         input logic [1:0] sin);
        reset = rst_n; clear = clr_n; load_enable = ld; shift_enable = sh;
        dir = dr; mode = md; parallel_in = pin; serial_in = sin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int eq, input int ec, input int ed, input int eso);
        check({tag, ".q"},    int'(parallel_out), eq);
        check({tag, ".cnt"},  int'(shift_count),  ec);
        check({tag, ".done"}, int'(done),         ed);
        check({tag, ".so"},   int'(serial_out),   eso);
    endtask

    // Reference model: register as a plain integer, shifts done with arithmetic.
    int m_q, m_cnt, m_done;

    task automatic model_step(input logic rst_n, input logic clr_n, input logic ld, input logic sh,
                              input logic dr, input logic [1:0] md, input int pin, input int sin);
        int fill;
        int eff_mode;
        eff_mode = (md == 2'b11) ? 0 : int'(md);
        if (!rst_n || !clr_n) begin
            m_q = 0; m_cnt = 0; m_done = 0;
        end else if (ld) begin
            m_q = pin & MASK; m_cnt = 0; m_done = 0;
        end else if (sh && m_done == 0) begin
            if (!dr) begin
                if (eff_mode == 1)      fill = m_q % (1 << D);
                else if (eff_mode == 2) fill = (m_q >= (1 << (W - 1))) ? DMASK : 0;
                else                    fill = sin;
                m_q = (m_q / (1 << D)) + fill * (1 << (W - D));
            end else begin
                if (eff_mode == 1)      fill = m_q / (1 << (W - D));
                else if (eff_mode == 2) fill = 0;
                else                    fill = sin;
                m_q = (m_q * (1 << D) + fill) % (1 << W);
            end
            m_cnt = m_cnt + 1;
            m_done = (m_cnt == STEPS) ? 1 : 0;
        end
    endtask

    function automatic int model_so(input logic dr);
        return dr ? (m_q / (1 << (W - D))) : (m_q % (1 << D));
    endfunction

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);

        vecs[0]  = mk(0, 1, 0, 0, 0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 0, 2'b00);
        vecs[1]  = mk(1, 1, 1, 0, 0, 2'b00, 8'hB4, 2'b11, 8'hB4, 0, 0, 2'b00);
        vecs[2]  = mk(1, 1, 0, 1, 0, 2'b00, 8'h00, 2'b11, 8'hED, 1, 0, 2'b01);
        vecs[3]  = mk(1, 1, 1, 0, 1, 2'b01, 8'h81, 2'b00, 8'h81, 0, 0, 2'b10);
        vecs[4]  = mk(1, 1, 0, 1, 1, 2'b01, 8'h00, 2'b00, 8'h06, 1, 0, 2'b00);
        vecs[5]  = mk(1, 1, 0, 1, 1, 2'b01, 8'h00, 2'b00, 8'h18, 2, 0, 2'b00);
        vecs[6]  = mk(1, 1, 0, 1, 1, 2'b01, 8'h00, 2'b00, 8'h60, 3, 0, 2'b01);
        vecs[7]  = mk(1, 1, 0, 1, 1, 2'b01, 8'h00, 2'b00, 8'h81, 4, 1, 2'b10);
        vecs[8]  = mk(1, 1, 0, 1, 1, 2'b01, 8'h00, 2'b00, 8'h81, 4, 1, 2'b10);
        vecs[9]  = mk(1, 1, 1, 0, 0, 2'b00, 8'h3C, 2'b00, 8'h3C, 0, 0, 2'b00);
        vecs[10] = mk(1, 1, 1, 0, 0, 2'b10, 8'h80, 2'b00, 8'h80, 0, 0, 2'b00);
        vecs[11] = mk(1, 1, 0, 1, 0, 2'b10, 8'h00, 2'b00, 8'hE0, 1, 0, 2'b00);
        vecs[12] = mk(1, 1, 0, 1, 0, 2'b10, 8'h00, 2'b00, 8'hF8, 2, 0, 2'b00);
        vecs[13] = mk(1, 1, 1, 0, 1, 2'b10, 8'h81, 2'b00, 8'h81, 0, 0, 2'b10);
        vecs[14] = mk(1, 1, 0, 1, 1, 2'b10, 8'h00, 2'b00, 8'h04, 1, 0, 2'b00);
        vecs[15] = mk(1, 1, 1, 1, 0, 2'b00, 8'hA5, 2'b00, 8'hA5, 0, 0, 2'b01);
        vecs[16] = mk(1, 0, 1, 1, 0, 2'b00, 8'h5A, 2'b00, 8'h00, 0, 0, 2'b00);
        vecs[17] = mk(1, 1, 1, 0, 1, 2'b11, 8'h3C, 2'b10, 8'h3C, 0, 0, 2'b00);
        vecs[18] = mk(1, 1, 0, 1, 1, 2'b11, 8'h00, 2'b10, 8'hF2, 1, 0, 2'b11);
        vecs[19] = mk(1, 1, 0, 1, 0, 2'b00, 8'h00, 2'b01, 8'h7C, 2, 0, 2'b00);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst_n, vecs[i].clr_n, vecs[i].ld, vecs[i].sh,
                  vecs[i].dr, vecs[i].md, vecs[i].pin, vecs[i].sin);
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].eq), int'(vecs[i].ec),
                      int'(vecs[i].ed), int'(vecs[i].eso));
        end

        // serial_out follows dir with no clock edge: 8'h7C low digit 00, top digit 01
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 2'b00);
        #1;
        check("so_dir_left", int'(serial_out), 1);
        dir = 1'b0;
        #1;
        check("so_dir_right", int'(serial_out), 0);

        // Reset mid-pass: 3C -> 0F -> 03, then reset between edges holds until the edge
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h3C, 2'b00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00);
        tick();
        tick();
        check_all("mid_pre", 8'h03, 2, 0, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("mid_hold", 8'h03, 2, 0, 2'b11);
        tick();
        check_all("mid_rst", 0, 0, 0, 0);

        // Randomized run against the reference model
        m_q = 0; m_cnt = 0; m_done = 0;
        for (int n = 0; n < 400; n++) begin
            logic       r_rst, r_clr, r_ld, r_sh, r_dr;
            logic [1:0] r_md, r_sin;
            logic [7:0] r_pin;
            r_rst = ($urandom_range(0, 49) != 0);
            r_clr = ($urandom_range(0, 39) != 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_sh  = ($urandom_range(0, 3) != 0);
            r_dr  = 1'($urandom);
            r_md  = 2'($urandom);
            r_sin = 2'($urandom);
            r_pin = 8'($urandom);
            if (n == 0) r_rst = 1'b0;
            drive(r_rst, r_clr, r_ld, r_sh, r_dr, r_md, r_pin, r_sin);
            model_step(r_rst, r_clr, r_ld, r_sh, r_dr, r_md, int'(r_pin), int'(r_sin));
            tick();
            check_all($sformatf("rnd%0d", n), m_q, m_cnt, m_done, model_so(r_dr));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
